coreriscv_axi4_data_array_resp: RTL and testbench

Responder end of the data-array request channel. Accepts one arbitrated data-array request per cycle (13-bit byte address, write flag, 64-bit write data, 8-bit byte mask, way enable, 2-bit source tag), performs byte-masked writes into an 8 KiB single-way array, and returns read data tagged with the requesting source. Read responses pass through a 2-entry response queue with valid/ready backpressure. Sits directly downstream of the 4-input data-array arbiter inside the L1 data cache.

---
 rtl/coreriscv_axi4_data_array_resp_pkg.sv | 29 ++
 rtl/coreriscv_axi4_resp_queue.sv | 68 ++++++
 rtl/coreriscv_axi4_data_array_resp.sv | 108 ++++++++++
 tb/tb_coreriscv_axi4_data_array_resp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coreriscv_axi4_data_array_resp_pkg.sv
// Shared types and constants for the L1 data-array request channel.
// The request bundle layout is common to the arbiter and the responder.
package coreriscv_axi4_data_array_resp_pkg;

   localparam int unsigned DaAddrW = 13;
   localparam int unsigned DaDataW = 64;
   localparam int unsigned DaMaskW = DaDataW / 8;
   localparam int unsigned SrcW    = 2;

   typedef struct packed {
      logic [DaAddrW-1:0] addr;
      logic               write;
      logic [DaDataW-1:0] wdata;
      logic [DaMaskW-1:0] wmask;
      logic               way_en;
   } data_req_t;

   function automatic logic [DaDataW-1:0] merge_bytes(input logic [DaDataW-1:0] old_data,
                                                      input logic [DaDataW-1:0] new_data,
                                                      input logic [DaMaskW-1:0] mask);
      logic [DaDataW-1:0] res;
      res = old_data;
      for (int i = 0; i < int'(DaMaskW); i++) begin
         if (mask[i]) res[8*i +: 8] = new_data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/coreriscv_axi4_resp_queue.sv
// Small generic FIFO with valid/ready on both sides and an occupancy count.
// Reset is synchronous and active-low; storage is not cleared.
module coreriscv_axi4_resp_queue #(
   parameter int unsigned Width = 66,
   parameter int unsigned Depth = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         enq_valid_i,
   output logic                         enq_ready_o,
   input  logic [Width-1:0]             enq_data_i,
   output logic                         deq_valid_o,
   input  logic                         deq_ready_i,
   output logic [Width-1:0]             deq_data_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             enq_fire, deq_fire;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + 1'b1;
   endfunction

   assign enq_ready_o = (count_q != CntW'(Depth));
   assign deq_valid_o = (count_q != '0);
   assign deq_data_o  = mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign enq_fire    = enq_valid_i & enq_ready_o;
   assign deq_fire    = deq_valid_o & deq_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq_fire) wr_ptr_d = next_ptr(wr_ptr_q);
      if (deq_fire) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({enq_fire, deq_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq_fire) mem_q[wr_ptr_q] <= enq_data_i;
   end

endmodule

// File: rtl/coreriscv_axi4_data_array_resp.sv
// Data-array responder: byte-masked single-way array, one-stage read pipeline,
// and a credit-limited response queue echoing the requester id.
module coreriscv_axi4_data_array_resp
   import coreriscv_axi4_data_array_resp_pkg::*;
#(
   parameter int unsigned ADDR_W     = 13,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  io_req_ready,
   input  logic                  io_req_valid,
   input  logic [ADDR_W-1:0]     io_req_bits_addr,
   input  logic                  io_req_bits_write,
   input  logic [DATA_W-1:0]     io_req_bits_wdata,
   input  logic [DATA_W/8-1:0]   io_req_bits_wmask,
   input  logic                  io_req_bits_way_en,
   input  logic [SrcW-1:0]       io_req_source,
   input  logic                  io_resp_ready,
   output logic                  io_resp_valid,
   output logic [DATA_W-1:0]     io_resp_bits_data,
   output logic [SrcW-1:0]       io_resp_bits_source
);

   localparam int unsigned IdxW  = ADDR_W - 3;
   localparam int unsigned Words = 1 << IdxW;
   localparam int unsigned QW    = SrcW + DATA_W;
   localparam int unsigned CntW  = $clog2(RESP_DEPTH + 1);
   localparam int unsigned OutW  = CntW + 1;

   data_req_t         req;
   logic [IdxW-1:0]   req_idx;
   logic              req_fire, rd_fire, wr_fire, resp_fire;

   logic [DATA_W-1:0] mem_q [Words];
   logic [DATA_W-1:0] rdata_q;
   logic              s1_valid_q, s1_valid_d;
   logic [SrcW-1:0]   s1_source_q, s1_source_d;

   logic [CntW-1:0]   q_count;
   logic [QW-1:0]     q_data;
   logic [OutW-1:0]   outstanding;
   logic              credit_ok;
   logic              unused_enq_ready;
   logic              unused_addr_lsb;

   assign req = '{
      addr:   io_req_bits_addr,
      write:  io_req_bits_write,
      wdata:  io_req_bits_wdata,
      wmask:  io_req_bits_wmask,
      way_en: io_req_bits_way_en
   };

   assign req_idx         = req.addr[ADDR_W-1:3];
   assign unused_addr_lsb = ^req.addr[2:0];

   // Credits cover the stage-1 slot plus queued entries, so the queue never overflows.
   assign outstanding  = OutW'(s1_valid_q) + OutW'(q_count);
   assign credit_ok    = (outstanding < OutW'(RESP_DEPTH));
   assign resp_fire    = io_resp_valid & io_resp_ready;
   assign io_req_ready = reset & (credit_ok | resp_fire);

   assign req_fire = io_req_valid & io_req_ready;
   assign wr_fire  = req_fire & req.write;
   assign rd_fire  = req_fire & ~req.write;

   always_ff @(posedge clk) begin
      if (wr_fire && req.way_en) begin
         mem_q[req_idx] <= merge_bytes(mem_q[req_idx], req.wdata, req.wmask);
      end
      if (rd_fire) rdata_q <= mem_q[req_idx];
   end

   always_comb begin
      s1_valid_d  = rd_fire;
      s1_source_d = rd_fire ? io_req_source : s1_source_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         s1_source_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_source_q <= s1_source_d;
      end
   end

   coreriscv_axi4_resp_queue #(
      .Width (QW),
      .Depth (RESP_DEPTH)
   ) u_resp_queue (
      .clk_i       (clk),
      .rst_ni      (reset),
      .enq_valid_i (s1_valid_q),
      .enq_ready_o (unused_enq_ready),
      .enq_data_i  ({s1_source_q, rdata_q}),
      .deq_valid_o (io_resp_valid),
      .deq_ready_i (io_resp_ready),
      .deq_data_o  (q_data),
      .count_o     (q_count)
   );

   assign {io_resp_bits_source, io_resp_bits_data} = q_data;

endmodule

// File: tb/tb_coreriscv_axi4_data_array_resp.sv
// Randomized and directed bench for the data-array responder, checked every cycle
// against a transaction-level model of the array and the response stream.
module tb_coreriscv_axi4_data_array_resp;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_req_ready;
   logic        io_req_valid;
   logic [12:0] io_req_bits_addr;
   logic        io_req_bits_write;
   logic [63:0] io_req_bits_wdata;
   logic [7:0]  io_req_bits_wmask;
   logic        io_req_bits_way_en;
   logic [1:0]  io_req_source;
   logic        io_resp_ready;
   logic        io_resp_valid;
   logic [63:0] io_resp_bits_data;
   logic [1:0]  io_resp_bits_source;

   always #5 clk = ~clk;

   coreriscv_axi4_data_array_resp dut (
      .clk                 (clk),
      .reset               (reset),
      .io_req_ready        (io_req_ready),
      .io_req_valid        (io_req_valid),
      .io_req_bits_addr    (io_req_bits_addr),
      .io_req_bits_write   (io_req_bits_write),
      .io_req_bits_wdata   (io_req_bits_wdata),
      .io_req_bits_wmask   (io_req_bits_wmask),
      .io_req_bits_way_en  (io_req_bits_way_en),
      .io_req_source       (io_req_source),
      .io_resp_ready       (io_resp_ready),
      .io_resp_valid       (io_resp_valid),
      .io_resp_bits_data   (io_resp_bits_data),
      .io_resp_bits_source (io_resp_bits_source)
   );

   typedef struct {
      logic [63:0] data;
      logic [1:0]  src;
      int          avail;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        mq[$];
   logic [63:0] mdl_mem [1024];
   int          cyc = 0;
   bit          cmp_en = 1'b0;
   logic        obs_ready, obs_valid;
   logic [63:0] obs_data;
   logic [1:0]  obs_src;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic step(input bit rst_v, input bit vld, input bit wr, input logic [12:0] a,
                       input logic [63:0] wd, input logic [7:0] wm, input bit we,
                       input logic [1:0] src, input bit rr);
      bit   exp_valid, exp_ready, fire, deq;
      exp_t e;
      @(negedge clk);
      reset              = rst_v;
      io_req_valid       = vld;
      io_req_bits_write  = wr;
      io_req_bits_addr   = a;
      io_req_bits_wdata  = wd;
      io_req_bits_wmask  = wm;
      io_req_bits_way_en = we;
      io_req_source      = src;
      io_resp_ready      = rr;
      #1;
      obs_ready = io_req_ready;
      obs_valid = io_resp_valid;
      obs_data  = io_resp_bits_data;
      obs_src   = io_resp_bits_source;
      exp_valid = (mq.size() > 0) && (mq[0].avail <= cyc);
      exp_ready = rst_v && ((mq.size() < 2) || (exp_valid && rr));
      chk("req_ready", obs_ready, exp_ready);
      if (cmp_en) begin
         chk("resp_valid", obs_valid, exp_valid);
         if (exp_valid) begin
            chk("resp_data", obs_data, mq[0].data);
            chk("resp_source", obs_src, mq[0].src);
         end
      end
      fire = vld && exp_ready;
      deq  = exp_valid && rr;
      @(posedge clk);
      if (!rst_v) begin
         mq.delete();
      end else begin
         if (deq) mq.delete(0);
         if (fire && wr && we) begin
            for (int i = 0; i < 8; i++)
               if (wm[i]) mdl_mem[a[12:3]][8*i +: 8] = wd[8*i +: 8];
         end else if (fire && !wr) begin
            e.data  = mdl_mem[a[12:3]];
            e.src   = src;
            e.avail = cyc + 2;
            mq.push_back(e);
         end
      end
      cyc++;
   endtask

   task automatic wr_req(input logic [12:0] a, input logic [63:0] d, input logic [7:0] m,
                         input bit we);
      step(1'b1, 1'b1, 1'b1, a, d, m, we, 2'd0, 1'b1);
   endtask

   task automatic rd_req(input logic [12:0] a, input logic [1:0] src, input bit rr);
      step(1'b1, 1'b1, 1'b0, a, 64'd0, 8'd0, 1'b1, src, rr);
   endtask

   task automatic idle(input bit rr);
      step(1'b1, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 1'b0, 2'd0, rr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          nresp;
      int          first;
      logic [12:0] a;
      logic [9:0]  idx;

      // Reset: state is unknown before the first reset edge.
      step(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0);
      cmp_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0);
      chk("rst_ready", obs_ready, 0);
      chk("rst_valid", obs_valid, 0);
      idle(1'b1);
      chk("ready_after_release", obs_ready, 1);

      for (int i = 0; i < 1024; i++) begin
         a = 13'(i * 8);
         wr_req(a, {$urandom, $urandom}, 8'hFF, 1'b1);
      end

      // Full write, then read back with source 2.
      wr_req(13'h008, 64'h1122334455667788, 8'hFF, 1'b1);
      rd_req(13'h008, 2'd2, 1'b1);
      idle(1'b1);
      chk("lat_not_early", obs_valid, 0);
      idle(1'b1);
      chk("lat_valid", obs_valid, 1);
      chk("lat_data", obs_data, 64'h1122334455667788);
      chk("lat_src", obs_src, 2);

      // Partial write of the low four bytes.
      wr_req(13'h008, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b1);
      rd_req(13'h008, 2'd0, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("mask_data", obs_data, 64'h11223344BBBBBBBB);

      // Disabled way: no update, no response.
      wr_req(13'h008, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
      idle(1'b1);
      chk("wr_no_resp1", obs_valid, 0);
      idle(1'b1);
      chk("wr_no_resp2", obs_valid, 0);
      rd_req(13'h008, 2'd1, 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("wayen0_data", obs_data, 64'h11223344BBBBBBBB);

      // Backpressure with three back-to-back reads.
      wr_req(13'h010, 64'h00000000000000A1, 8'hFF, 1'b1);
      wr_req(13'h018, 64'h00000000000000B2, 8'hFF, 1'b1);
      wr_req(13'h020, 64'h00000000000000C3, 8'hFF, 1'b1);
      rd_req(13'h010, 2'd0, 1'b0);
      chk("bp_ready1", obs_ready, 1);
      rd_req(13'h018, 2'd1, 1'b0);
      chk("bp_ready2", obs_ready, 1);
      rd_req(13'h020, 2'd3, 1'b0);
      chk("bp_ready3_blocked", obs_ready, 0);
      rd_req(13'h020, 2'd3, 1'b1);
      chk("bp_ready_on_deq", obs_ready, 1);
      chk("bp_resp1_data", obs_data, 64'hA1);
      chk("bp_resp1_src", obs_src, 0);
      idle(1'b1);
      chk("bp_resp2_data", obs_data, 64'hB2);
      chk("bp_resp2_src", obs_src, 1);
      idle(1'b1);
      chk("bp_resp3_data", obs_data, 64'hC3);
      chk("bp_resp3_src", obs_src, 3);
      idle(1'b1);
      chk("bp_drained", obs_valid, 0);

      // Streaming reads at full rate.
      nresp = 0;
      first = -1;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            rd_req(13'((i + 32) * 8), 2'(i), 1'b1);
            chk("stream_ready", obs_ready, 1);
         end else begin
            idle(1'b1);
         end
         if (obs_valid === 1'b1) begin
            nresp++;
            if (first < 0) first = i;
         end
      end
      chk("stream_count", 64'(nresp), 16);
      chk("stream_first", 64'(first), 2);

      // Reset with two reads outstanding.
      rd_req(13'h010, 2'd1, 1'b0);
      rd_req(13'h018, 2'd2, 1'b0);
      step(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0);
      chk("rst2_ready", obs_ready, 0);
      step(1'b0, 1'b0, 1'b0, 13'd0, 64'd0, 8'd0, 1'b0, 2'd0, 1'b0);
      chk("rst2_valid_cleared", obs_valid, 0);
      rd_req(13'h008, 2'd3, 1'b1);
      chk("rst2_ready_release", obs_ready, 1);
      nresp = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         if (obs_valid === 1'b1) begin
            nresp++;
            chk("rst2_data", obs_data, 64'h11223344BBBBBBBB);
         end
      end
      chk("rst2_one_resp", 64'(nresp), 1);

      // Random traffic with occasional resets and a hot address range.
      for (int n = 0; n < 3000; n++) begin
         idx = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
         a   = {idx, 3'($urandom)};
         step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), a, {$urandom, $urandom}, 8'($urandom),
              ($urandom_range(0, 7) != 0), 2'($urandom), ($urandom_range(0, 2) != 0));
      end
      for (int n = 0; n < 6; n++) idle(1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
